// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: freezes everything on outstanding
// data-memory accesses, inserts load-use bubbles, flushes IF/ID on taken branches.
module pipe_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             mem_start_o,
    input  logic             ID_EX_MemRead_i,
    input  logic [4:0]       ID_EX_Rt_i,
    input  logic [4:0]       IF_ID_Rs_i,
    input  logic [4:0]       IF_ID_Rt_i,
    input  logic             branch_taken_i,
    output logic             pcEnable_o,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {RUN, MISS, ERROR} state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                mem_stall;
    logic                load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        mem_stall = 1'b0;
        case (state)
            RUN:     mem_stall = mem_req_i && !mem_ack_i;
            MISS:    mem_stall = !mem_ack_i;
            default: mem_stall = 1'b1;
        endcase
    end

    assign load_use = ID_EX_MemRead_i && (ID_EX_Rt_i != 5'd0) &&
                      ((ID_EX_Rt_i == IF_ID_Rs_i) || (ID_EX_Rt_i == IF_ID_Rt_i));

    assign mem_start_o = (state == RUN) && mem_req_i;
    assign pcEnable_o  = !mem_stall;

    // A memory stall freezes everything without a bubble; a load-use hazard defers any branch.
    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        if (mem_stall) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
        end else if (load_use) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= RUN;
            wait_cnt    <= '0;
            err_o       <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (mem_stall)
                stall_cnt_o <= sat_inc(stall_cnt_o);
            case (state)
                RUN: begin
                    if (mem_req_i && !mem_ack_i) begin
                        state    <= MISS;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MISS: begin
                    // Ack on the last allowed cycle takes precedence over the timeout.
                    if (mem_ack_i) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        state <= ERROR;
                        err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state <= ERROR;
                    err_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
